// File: rtl/uart_echo_checker.sv
// uart_echo_checker: stop-and-wait UART echo tester (8N1 serializer, deserializer, run control).
module uart_echo_checker #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NUM_BYTES    = 256,
  parameter logic [7:0]  SEED         = 8'h00,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  output logic        tx_o,
  input  logic        rx_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_cnt_o
);

  localparam int unsigned CNT_W      = $clog2(CLKS_PER_BIT);
  localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TMO_W      = $clog2(TMO_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYCLES - 1);
  localparam logic [15:0]      K_LAST    = 16'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_START, S_TX_DATA, S_TX_STOP, S_WAIT_ECHO, S_CHECK, S_DONE
  } state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [15:0]      r_k;
  logic [7:0]       r_byte, w_byte_d;
  logic [7:0]       r_shift, w_shift_d;
  logic             r_tx, w_tx_d;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [15:0]      r_err_cnt;
  logic             r_pass, r_timeout;
  logic             w_bit_end, w_tmo_hit, w_start, w_err_inc, w_overwrite;

  rx_state_t        r_rx_state;
  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_idx;
  logic [7:0]       r_rx_shift, r_echo_byte;
  logic             r_echo_ferr, r_pending;
  logic             w_rx_en, w_rx_done;

  assign w_bit_end   = (r_clk_cnt == BIT_LAST);
  assign w_tmo_hit   = (r_tmo_cnt == TMO_LAST);
  assign w_start     = (r_state == S_IDLE) && start_i;
  assign w_rx_en     = (r_state != S_IDLE);
  assign w_rx_done   = w_rx_en && (r_rx_state == RX_STOP) && (r_rx_cnt == BIT_LAST);
  // A new frame landing on an unconsumed one is an error; in CHECK the old one is consumed instead.
  assign w_overwrite = w_rx_done && r_pending && (r_state != S_CHECK);
  assign w_err_inc   = ((r_state == S_CHECK) && ((r_echo_byte != r_byte) || r_echo_ferr)) || w_overwrite;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:      if (start_i) w_next_state = S_TX_START;
      S_TX_START:  if (w_bit_end) w_next_state = S_TX_DATA;
      S_TX_DATA:   if (w_bit_end && (r_bit_idx == 3'd7)) w_next_state = S_TX_STOP;
      S_TX_STOP:   if (w_bit_end) w_next_state = S_WAIT_ECHO;
      S_WAIT_ECHO: begin
        if (r_pending)      w_next_state = S_CHECK;
        else if (w_tmo_hit) w_next_state = S_DONE;
      end
      S_CHECK:     w_next_state = (r_k == K_LAST) ? S_DONE : S_TX_START;
      S_DONE:      w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // tx_o is registered from the next state so the line never glitches between bits.
  always_comb begin
    w_byte_d = r_byte;
    if (w_start)                   w_byte_d = SEED;
    else if (r_state == S_CHECK)   w_byte_d = r_byte + 8'd1;
    w_shift_d = r_shift;
    if (w_next_state == S_TX_START)             w_shift_d = w_byte_d;
    else if ((r_state == S_TX_DATA) && w_bit_end) w_shift_d = {1'b0, r_shift[7:1]};
    case (w_next_state)
      S_TX_START: w_tx_d = 1'b0;
      S_TX_DATA:  w_tx_d = w_shift_d[0];
      default:    w_tx_d = 1'b1;
    endcase
    tx_o      = r_tx;
    busy_o    = (r_state != S_IDLE);
    done_o    = (r_state == S_DONE);
    pass_o    = r_pass;
    timeout_o = r_timeout;
    err_cnt_o = r_err_cnt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_k       <= '0;
      r_byte    <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_tmo_cnt <= '0;
      r_err_cnt <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_byte  <= w_byte_d;
      r_shift <= w_shift_d;
      r_tx    <= w_tx_d;

      if ((w_next_state != r_state) || w_bit_end) r_clk_cnt <= '0;
      else                                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);

      if (w_start)                                   r_bit_idx <= '0;
      else if ((r_state == S_TX_DATA) && w_bit_end)  r_bit_idx <= r_bit_idx + 3'd1;

      if (w_start)                 r_k <= '0;
      else if (r_state == S_CHECK) r_k <= r_k + 16'd1;

      if (r_state != S_WAIT_ECHO) r_tmo_cnt <= '0;
      else                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

      if (w_start)                             r_err_cnt <= '0;
      else if (w_err_inc && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 16'd1;

      if (w_start) r_timeout <= 1'b0;
      else if ((r_state == S_WAIT_ECHO) && !r_pending && w_tmo_hit) r_timeout <= 1'b1;

      if (w_start)                r_pass <= 1'b0;
      else if (r_state == S_DONE) r_pass <= (r_err_cnt == '0) && !r_timeout;

      if (w_start)                 r_pending <= 1'b0;
      else if (w_rx_done)          r_pending <= 1'b1;
      else if (r_state == S_CHECK) r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_idx    <= '0;
      r_rx_shift  <= '0;
      r_echo_byte <= '0;
      r_echo_ferr <= 1'b0;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      if (!w_rx_en) begin
        r_rx_state <= RX_IDLE;
        r_rx_cnt   <= '0;
      end else begin
        case (r_rx_state)
          RX_IDLE: begin
            r_rx_cnt <= '0;
            if (r_rx_prev && !r_rx_sync) r_rx_state <= RX_START;
          end
          RX_START: begin
            if (r_rx_cnt == HALF_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_idx   <= '0;
              r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
            end else r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
          RX_DATA: begin
            if (r_rx_cnt == BIT_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
              r_rx_idx   <= r_rx_idx + 3'd1;
              if (r_rx_idx == 3'd7) r_rx_state <= RX_STOP;
            end else r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
          RX_STOP: begin
            if (r_rx_cnt == BIT_LAST) begin
              r_rx_cnt    <= '0;
              r_rx_state  <= RX_IDLE;
              r_echo_byte <= r_rx_shift;
              r_echo_ferr <= !r_rx_sync;
            end else r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_checker.sv
module tb_uart_echo_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        start_a, start_b, start_em;
  logic        stuck_a, rx_em;
  logic        rx_a;
  logic        tx_a, busy_a, done_a, pass_a, tmo_a;
  logic        tx_b, busy_b, done_b, pass_b, tmo_b;
  logic        tx_em, busy_em, done_em, pass_em, tmo_em;
  logic [15:0] err_a, err_b, err_em;

  assign rx_a = stuck_a ? 1'b1 : tx_a;

  uart_echo_checker #(.CLKS_PER_BIT(4), .NUM_BYTES(4), .SEED(8'hA5), .TIMEOUT_BITS(40)) u_a (
    .clk(clk), .resetn(resetn), .start_i(start_a), .tx_o(tx_a), .rx_i(rx_a),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .timeout_o(tmo_a), .err_cnt_o(err_a));

  uart_echo_checker #(.CLKS_PER_BIT(4), .NUM_BYTES(4), .SEED(8'hFE), .TIMEOUT_BITS(40)) u_b (
    .clk(clk), .resetn(resetn), .start_i(start_b), .tx_o(tx_b), .rx_i(tx_b),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .timeout_o(tmo_b), .err_cnt_o(err_b));

  uart_echo_checker #(.CLKS_PER_BIT(8), .NUM_BYTES(4), .SEED(8'h30), .TIMEOUT_BITS(40)) u_em (
    .clk(clk), .resetn(resetn), .start_i(start_em), .tx_o(tx_em), .rx_i(rx_em),
    .busy_o(busy_em), .done_o(done_em), .pass_o(pass_em), .timeout_o(tmo_em), .err_cnt_o(err_em));

  int   mon_sel = 0;
  logic mon_tx, mon_done;
  int   mon_cpb;

  always_comb begin
    case (mon_sel)
      1:       begin mon_tx = tx_b;  mon_done = done_b;  mon_cpb = 4; end
      2:       begin mon_tx = tx_em; mon_done = done_em; mon_cpb = 8; end
      default: begin mon_tx = tx_a;  mon_done = done_a;  mon_cpb = 4; end
    endcase
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  always @(negedge clk) begin
    if (mon_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  logic [7:0]  mon_q[$];
  int unsigned mon_t0_q[$];

  // Decodes frames on the selected tx line at bit centres.
  always begin : frame_mon
    logic [7:0]  b;
    int unsigned t0;
    @(negedge clk);
    if (mon_tx === 1'b0) begin
      t0 = cyc;
      b  = '0;
      repeat (mon_cpb / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (mon_cpb) @(negedge clk);
        b[i] = mon_tx;
      end
      repeat (mon_cpb) @(negedge clk);
      mon_q.push_back(b);
      mon_t0_q.push_back(t0);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0:       start_a  = 1'b1;
      1:       start_b  = 1'b1;
      default: start_em = 1'b1;
    endcase
    @(negedge clk);
    start_a  = 1'b0;
    start_b  = 1'b0;
    start_em = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned base, input int unsigned budget);
    int unsigned w = 0;
    while (done_cnt == base && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt != base), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frames(input string name, input int qb, input logic [7:0] seed, input int n);
    chk({name, "_nframes"}, 32'(mon_q.size() - qb), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (mon_q.size() > qb + i)
        chk($sformatf("%s_byte%0d", name, i), 32'(mon_q[qb + i]), 32'(8'(seed + 8'(i))));
    end
  endtask

  task automatic send_em(input logic [7:0] b, input logic stop_bit);
    rx_em = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_em = b[i];
      repeat (8) @(negedge clk);
    end
    rx_em = stop_bit;
    repeat (8) @(negedge clk);
    rx_em = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] masks;
    logic [3:0]  bad_stop;
    logic [15:0] exp_err;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int qb;
    int unsigned db;

    vecs[0] = '{"em_clean",      32'h0000_0000, 4'b0000, 16'd0, 1'b1};
    vecs[1] = '{"em_byte2_x01",  32'h0001_0000, 4'b0000, 16'd1, 1'b0};
    vecs[2] = '{"em_stop0_low",  32'h0000_0000, 4'b0001, 16'd1, 1'b0};
    vecs[3] = '{"em_two_errs",   32'h0000_8000, 4'b1000, 16'd2, 1'b0};
    vecs[4] = '{"em_data_and_fe",32'h0000_00FF, 4'b0001, 16'd1, 1'b0};

    resetn = 1'b0; start_a = 1'b0; start_b = 1'b0; start_em = 1'b0;
    stuck_a = 1'b0; rx_em = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_a",   32'(tx_a), 1);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_done_a", 32'(done_a), 0);
    chk("rst_pass_a", 32'(pass_a), 0);
    chk("rst_tmo_a",  32'(tmo_a), 0);
    chk("rst_err_a",  32'(err_a), 0);
    chk("rst_tx_b",   32'(tx_b), 1);
    chk("rst_busy_em",32'(busy_em), 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Loopback A5..A8
    mon_sel = 0;
    qb = mon_q.size(); db = done_cnt;
    pulse(0);
    chk("lb_tx_start_low", 32'(tx_a), 0);
    chk("lb_busy_rise",    32'(busy_a), 1);
    wait_done("lb", db, 1000);
    check_frames("lb", qb, 8'hA5, 4);
    chk("lb_done_pulses", 32'(done_cnt - db), 1);
    chk("lb_pass", 32'(pass_a), 1);
    chk("lb_err",  32'(err_a), 0);
    chk("lb_tmo",  32'(tmo_a), 0);
    chk("lb_busy_end", 32'(busy_a), 0);

    // Missing echo: timeout after 40 bit periods
    stuck_a = 1'b1;
    qb = mon_q.size(); db = done_cnt;
    pulse(0);
    wait_done("tmo", db, 2000);
    if (mon_t0_q.size() > qb)
      chk("tmo_done_latency", done_cyc - mon_t0_q[qb], 200);
    chk("tmo_flag", 32'(tmo_a), 1);
    chk("tmo_pass", 32'(pass_a), 0);
    chk("tmo_err",  32'(err_a), 0);
    repeat (60) @(negedge clk);
    check_frames("tmo", qb, 8'hA5, 1);
    stuck_a = 1'b0;

    // Reset in the middle of a data bit
    pulse(0);
    repeat (9) @(negedge clk);
    chk("mid_tx_bit1_low", 32'(tx_a), 0);
    resetn = 1'b0;
    #1;
    chk("async_rst_tx",   32'(tx_a), 1);
    chk("async_rst_busy", 32'(busy_a), 0);
    chk("async_rst_err",  32'(err_a), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    qb = mon_q.size(); db = done_cnt;
    pulse(0);
    wait_done("post_rst", db, 1000);
    check_frames("post_rst", qb, 8'hA5, 4);
    chk("post_rst_pass", 32'(pass_a), 1);
    chk("post_rst_err",  32'(err_a), 0);

    // Seed wrap FE,FF,00,01 with a stray start mid-run
    mon_sel = 1;
    repeat (2) @(negedge clk);
    qb = mon_q.size(); db = done_cnt;
    pulse(1);
    repeat (60) @(negedge clk);
    pulse(1);
    wait_done("wrap", db, 1000);
    chk("wrap_pass", 32'(pass_b), 1);
    chk("wrap_err",  32'(err_b), 0);
    repeat (80) @(negedge clk);
    check_frames("wrap", qb, 8'hFE, 4);
    chk("wrap_done_pulses", 32'(done_cnt - db), 1);
    chk("wrap_busy_end", 32'(busy_b), 0);

    // Bench echo model: corrupted data and framing errors
    mon_sel = 2;
    repeat (2) @(negedge clk);
    for (int v = 0; v < 5; v++) begin
      qb = mon_q.size(); db = done_cnt;
      pulse(2);
      for (int i = 0; i < 4; i++) begin
        int unsigned w = 0;
        while (mon_q.size() <= qb + i && w < 2000) begin
          @(negedge clk);
          w++;
        end
        if (mon_q.size() <= qb + i) begin
          chk($sformatf("%s_frame%0d_seen", vecs[v].name, i), 32'(mon_q.size() > qb + i), 1);
          break;
        end
        send_em(mon_q[qb + i] ^ vecs[v].masks[8*i +: 8], !vecs[v].bad_stop[i]);
      end
      wait_done(vecs[v].name, db, 2000);
      check_frames(vecs[v].name, qb, 8'h30, 4);
      chk({vecs[v].name, "_done_pulses"}, 32'(done_cnt - db), 1);
      chk({vecs[v].name, "_err"},  32'(err_em), 32'(vecs[v].exp_err));
      chk({vecs[v].name, "_pass"}, 32'(pass_em), 32'(vecs[v].exp_pass));
      chk({vecs[v].name, "_tmo"},  32'(tmo_em), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
